// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdc_pkg
// Brief    : Shared TDC constants and sequencer state encoding.
// Revision : 1.0
// ============================================================================
package tdc_pkg;

    localparam int c_DEF_TAPS     = 32;
    localparam int c_DEF_COARSE_W = 16;
    localparam int c_DEF_TIMEOUT  = 1000;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ARMED   = 3'd1;
    localparam logic [2:0] c_ST_RUN     = 3'd2;
    localparam logic [2:0] c_ST_CAPTURE = 3'd3;
    localparam logic [2:0] c_ST_ENCODE  = 3'd4;
    localparam logic [2:0] c_ST_HOLD    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = c_ST_IDLE,
        S_ARMED   = c_ST_ARMED,
        S_RUN     = c_ST_RUN,
        S_CAPTURE = c_ST_CAPTURE,
        S_ENCODE  = c_ST_ENCODE,
        S_HOLD    = c_ST_HOLD
    } tdc_state_t;

endpackage
`default_nettype wire

// File: rtl/therm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : therm_encoder
// Brief    : Counts consecutive ones from bit 0; ones above the first zero
//            (bubbles) are ignored.
// Revision : 1.0
// ============================================================================
module therm_encoder
    import tdc_pkg::*;
#(
    parameter  int TAPS   = c_DEF_TAPS,
    localparam int FINE_W = $clog2(TAPS + 1)
) (
    input  logic [TAPS-1:0]   i_taps,
    output logic [FINE_W-1:0] o_fine
);

    logic [FINE_W-1:0] w_cnt;
    logic              w_run;

    always_comb begin
        w_cnt = '0;
        w_run = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            if (w_run && i_taps[i]) begin
                w_cnt = w_cnt + 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign o_fine = w_cnt;

endmodule
`default_nettype wire

// File: rtl/tdc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tdc_sequencer
// Brief    : Delay-line TDC measurement sequencer: coarse cycle count, tap
//            snapshot, thermometer fine count, valid/ready result.
//            Optional abort timer enabled by macro TDC_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module tdc_sequencer
    import tdc_pkg::*;
#(
    parameter  int TAPS     = c_DEF_TAPS,
    parameter  int COARSE_W = c_DEF_COARSE_W,
`ifdef TDC_TIMEOUT_EN
    parameter  int TIMEOUT  = c_DEF_TIMEOUT,
`endif
    localparam int FINE_W   = $clog2(TAPS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_arm,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [TAPS-1:0]     i_taps,
    output logic                o_snap,
    output logic                o_busy,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic [COARSE_W-1:0] o_res_coarse,
    output logic [FINE_W-1:0]   o_res_fine,
    output logic                o_res_timeout
);

    tdc_state_t          r_state;
    tdc_state_t          w_state_next;
    logic [COARSE_W-1:0] r_coarse;
    logic [TAPS-1:0]     r_taps;
    logic [COARSE_W-1:0] r_res_coarse;
    logic [FINE_W-1:0]   r_res_fine;
    logic                r_res_timeout;
    logic [FINE_W-1:0]   w_fine;
    logic                w_timeout;
    logic                w_abort;
    logic                w_snap;
    logic                w_busy;
    logic                w_valid;

    therm_encoder #(
        .TAPS   (TAPS)
    ) u_therm_encoder (
        .i_taps (r_taps),
        .o_fine (w_fine)
    );

`ifdef TDC_TIMEOUT_EN
    localparam int                TMR_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  c_TMO_LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] r_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_state_next == S_ARMED && r_state != S_ARMED) begin
            r_timer <= '0;
        end else if (r_state == S_ARMED || r_state == S_RUN) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Asserted on the edge that brings the timer up to TIMEOUT.
    assign w_timeout = (r_state == S_ARMED || r_state == S_RUN) && (r_timer == c_TMO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_abort = w_timeout && !i_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_snap       = 1'b0;
        w_busy       = 1'b1;
        w_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_arm) w_state_next = S_ARMED;
            end
            S_ARMED: begin
                if (i_start && i_stop) w_state_next = S_CAPTURE;
                else if (w_abort)      w_state_next = S_HOLD;
                else if (i_start)      w_state_next = S_RUN;
            end
            S_RUN: begin
                if (i_stop)       w_state_next = S_CAPTURE;
                else if (w_abort) w_state_next = S_HOLD;
            end
            S_CAPTURE: begin
                w_snap       = 1'b1;
                w_state_next = S_ENCODE;
            end
            S_ENCODE: begin
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                w_valid = 1'b1;
                if (i_res_ready) w_state_next = i_arm ? S_ARMED : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coarse      <= '0;
            r_taps        <= '0;
            r_res_coarse  <= '0;
            r_res_fine    <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            // The stop edge itself also counts, so coarse = E_stop - E_start.
            if (r_state == S_ARMED && i_start) begin
                r_coarse <= '0;
            end else if (r_state == S_RUN && r_coarse != '1) begin
                r_coarse <= r_coarse + 1'b1;
            end

            if (r_state == S_CAPTURE) begin
                r_taps <= i_taps;
            end

            if (r_state == S_ENCODE) begin
                r_res_coarse  <= r_coarse;
                r_res_fine    <= w_fine;
                r_res_timeout <= 1'b0;
            end else if (w_abort) begin
                r_res_coarse  <= (r_state == S_RUN) ? r_coarse : '0;
                r_res_fine    <= '0;
                r_res_timeout <= 1'b1;
            end
        end
    end

    assign o_snap        = w_snap;
    assign o_busy        = w_busy;
    assign o_res_valid   = w_valid;
    assign o_res_coarse  = r_res_coarse;
    assign o_res_fine    = r_res_fine;
    assign o_res_timeout = r_res_timeout;

endmodule
`default_nettype wire

// File: tb/tb_tdc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_sequencer
// Brief    : Directed self-checking bench for tdc_sequencer.
// Revision : 1.0
// ============================================================================
module tb_tdc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        start;
    logic        stop;
    logic [31:0] taps;
    logic        snap;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_coarse;
    logic [5:0]  res_fine;
    logic        res_timeout;

    int errors = 0;
    int checks = 0;

`ifdef TDC_TIMEOUT_EN
    tdc_sequencer #(.TIMEOUT(100)) dut (
`else
    tdc_sequencer dut (
`endif
        .clk           (clk),
        .rst_n         (rst_n),
        .i_arm         (arm),
        .i_start       (start),
        .i_stop        (stop),
        .i_taps        (taps),
        .o_snap        (snap),
        .o_busy        (busy),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_coarse  (res_coarse),
        .o_res_fine    (res_fine),
        .o_res_timeout (res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Arm from IDLE, start, stop `gap` edges later, then run to HOLD.
    task automatic measure(input int gap, input logic [31:0] tp);
        arm = 1'b1; tick; arm = 1'b0;
        start = 1'b1; taps = tp;
        if (gap == 0) stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        if (gap > 0) begin
            repeat (gap - 1) tick;
            stop = 1'b1; tick; stop = 1'b0;
        end
        tick; tick;
    endtask

    task automatic release_result;
        res_ready = 1'b1; tick; res_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({snap, busy, res_valid, res_timeout, res_coarse, res_fine} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got snap=%b busy=%b valid=%b to=%b coarse=%0d fine=%0d, expected all 0",
                     snap, busy, res_valid, res_timeout, res_coarse, res_fine);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_thermometer;
        arm = 1'b1; tick; arm = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        repeat (4) tick;
        checks++;
        if (snap !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL therm_run: snap=%b busy=%b expected 0/1", snap, busy);
        end
        stop = 1'b1; taps = 32'h0000_00FF; tick; stop = 1'b0;
        checks++;
        if (snap !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL therm_snap: snap=%b valid=%b expected 1/0", snap, res_valid);
        end
        tick;
        checks++;
        if (snap !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL therm_encode: snap=%b valid=%b expected 0/0", snap, res_valid);
        end
        tick;
        checks++;
        if (res_valid !== 1'b1 || res_coarse !== 16'd5 || res_fine !== 6'd8 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL therm_result: valid=%b coarse=%0d fine=%0d to=%b expected 1/5/8/0",
                     res_valid, res_coarse, res_fine, res_timeout);
        end
        release_result;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_coarse !== 16'd5 || res_fine !== 6'd8) begin
            errors++;
            $display("FAIL therm_release: valid=%b busy=%b coarse=%0d fine=%0d expected 0/0/5/8",
                     res_valid, busy, res_coarse, res_fine);
        end
    endtask

    task automatic test_same_edge;
        measure(0, 32'hFFFF_FFFF);
        checks++;
        if (res_valid !== 1'b1 || res_coarse !== 16'd0 || res_fine !== 6'd32) begin
            errors++;
            $display("FAIL same_edge: valid=%b coarse=%0d fine=%0d expected 1/0/32", res_valid, res_coarse, res_fine);
        end
        release_result;
    endtask

    task automatic test_bubble;
        measure(3, 32'h0000_00F7);
        checks++;
        if (res_valid !== 1'b1 || res_coarse !== 16'd3 || res_fine !== 6'd3) begin
            errors++;
            $display("FAIL bubble: valid=%b coarse=%0d fine=%0d expected 1/3/3", res_valid, res_coarse, res_fine);
        end
        release_result;
        measure(1, 32'hFFFF_FFFE);
        checks++;
        if (res_coarse !== 16'd1 || res_fine !== 6'd0) begin
            errors++;
            $display("FAIL zero_fine: coarse=%0d fine=%0d expected 1/0", res_coarse, res_fine);
        end
        release_result;
    endtask

    task automatic test_back_to_back;
        int bad;
        measure(4, 32'h0000_FFFF);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            arm = i[0];
            tick;
            if (res_valid !== 1'b1 || busy !== 1'b1 || res_coarse !== 16'd4 || res_fine !== 6'd16) bad++;
        end
        arm = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, expected 0 (valid=%b busy=%b coarse=%0d fine=%0d)",
                     bad, res_valid, busy, res_coarse, res_fine);
        end
        res_ready = 1'b1; arm = 1'b1; tick; res_ready = 1'b0; arm = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_armed: valid=%b busy=%b expected 0/1", res_valid, busy);
        end
        start = 1'b1; taps = 32'h0000_0003; tick; start = 1'b0;
        tick;
        stop = 1'b1; tick; stop = 1'b0;
        tick; tick;
        checks++;
        if (res_valid !== 1'b1 || res_coarse !== 16'd2 || res_fine !== 6'd2) begin
            errors++;
            $display("FAIL b2b_result: valid=%b coarse=%0d fine=%0d expected 1/2/2", res_valid, res_coarse, res_fine);
        end
        release_result;
    endtask

    task automatic test_timeout;
        int n;
        arm = 1'b1; tick; arm = 1'b0;
`ifdef TDC_TIMEOUT_EN
        n = 0;
        while (res_valid !== 1'b1 && n < 300) begin
            tick;
            n++;
        end
        checks++;
        if (n != 100 || res_timeout !== 1'b1 || res_coarse !== 16'd0 || res_fine !== 6'd0) begin
            errors++;
            $display("FAIL timeout: cycles=%0d to=%b coarse=%0d fine=%0d expected 100/1/0/0",
                     n, res_timeout, res_coarse, res_fine);
        end
        release_result;
`else
        n = 1000;
        repeat (n) tick;
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: busy=%b valid=%b expected 1/0", busy, res_valid);
        end
        rst_n = 1'b0; #1 rst_n = 1'b1;
`endif
    endtask

    task automatic test_reset_abort;
        arm = 1'b1; tick; arm = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({snap, busy, res_valid, res_timeout, res_coarse, res_fine} !== 26'd0) begin
            errors++;
            $display("FAIL abort_outputs: snap=%b busy=%b valid=%b to=%b coarse=%0d fine=%0d expected all 0",
                     snap, busy, res_valid, res_timeout, res_coarse, res_fine);
        end
        #1 rst_n = 1'b1;
        tick;
        start = 1'b1; tick; start = 1'b0;
        stop = 1'b1; tick; stop = 1'b0;
        tick; tick;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_ignore: busy=%b valid=%b expected 0/0", busy, res_valid);
        end
        measure(2, 32'h0000_001F);
        checks++;
        if (res_valid !== 1'b1 || res_coarse !== 16'd2 || res_fine !== 6'd5) begin
            errors++;
            $display("FAIL abort_recover: valid=%b coarse=%0d fine=%0d expected 1/2/5", res_valid, res_coarse, res_fine);
        end
        release_result;
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; start = 1'b0; stop = 1'b0;
        taps = '0; res_ready = 1'b0;
        test_reset;
        test_thermometer;
        test_same_edge;
        test_bubble;
        test_back_to_back;
        test_timeout;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
